shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Two-requester controller for the WIDTH-bit load/shift register datapath (`shifterbit` chain).
- Arbitrates shift commands from requester A and requester B.
- Drives the shifter's load_n/load_val/shift/asr controls to load the operand, then applies the requested number of single-bit right shifts.
- Captures the shifter output and returns it with a response pulse tagged with the requester id.

Parameters:
- WIDTH, 8, data width of the shifter being sequenced.
- CNT_W, 4, width of the shift-count fields on each request port.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req_a  in  1  requester A command valid; held until gnt_a
- data_a  in  WIDTH  A operand
- cnt_a  in  CNT_W  A shift count
- asr_a  in  1  A arithmetic (1) / logical (0) shift
- gnt_a  out  1  A command accepted (one-cycle pulse)
- req_b, data_b, cnt_b, asr_b, gnt_b  same as A, for requester B
- sh_load_n  out  1  to shifter: parallel load, active-low
- sh_load_val  out  WIDTH  to shifter: load value
- sh_shift  out  1  to shifter: shift-right enable
- sh_asr  out  1  to shifter: MSB fill = old MSB when 1, 0 when 0
- sh_q  in  WIDTH  from shifter: current register value
- busy  out  1  high in every state except IDLE
- rsp_valid  out  1  result valid (one-cycle pulse)
- rsp_id  out  1  0 = A, 1 = B; valid with rsp_valid
- rsp_data  out  WIDTH  captured result; holds until next capture

Behaviour:
- Reset values:
  - state = IDLE; gnt_a = gnt_b = 0; rsp_valid = 0; rsp_id = 0; rsp_data = 0; busy = 0.
  - sh_load_n = 1, sh_shift = 0, sh_asr = 0, sh_load_val = 0.
  - Round-robin pointer last = B, so A wins the first tie.
- Reset mid-operation: return to IDLE on the next edge. No gnt or rsp is issued. Any latched command is discarded.
- FSM states: IDLE, LOAD, SHIFT, DONE. All outputs are registered or decoded from state plus latched command registers.
- IDLE:
  - Shifter controls are inactive.
  - On an edge with req_a or req_b high, select the winner and latch its data, cnt, asr and id.
  - Set rem = min(cnt, WIDTH). Counts above WIDTH saturate to WIDTH.
  - Update last = winner and go to LOAD.
- Arbitration: a single request wins. If both request, the one not equal to last wins.
- LOAD (1 cycle):
  - gnt_<winner> = 1.
  - sh_load_n = 0, sh_load_val = latched data, sh_asr = latched asr, sh_shift = 0.
  - Next state: DONE if rem == 0, else SHIFT.
- SHIFT (rem cycles):
  - sh_load_n = 1, sh_shift = 1, sh_asr held.
  - rem decrements each edge. Exit to DONE on the edge where rem == 1.
- DONE (1 cycle):
  - sh_shift = 0, sh_load_n = 1.
  - At the closing edge: rsp_data <= sh_q, rsp_id <= latched id, rsp_valid <= 1, state <= IDLE.
- rsp_valid is high for exactly the first IDLE cycle after DONE. Acceptance of a new request on that same edge is allowed.
- Latency: with the accept edge at t0, LOAD is cycle 1, SHIFT is cycles 2..N+1, DONE is cycle N+2, and rsp_valid is in cycle N+3. N = 0 gives rsp_valid in cycle 3.
- Requests are sampled only in IDLE. A requester must drop req, or present its next command, after seeing gnt. A req still high on return to IDLE is treated as a new command.
- Input changes on data/cnt/asr after the accept edge have no effect.

Optional Feature:
- Macro: SHIFTCTL_FIXED_PRIO_EN.
- When defined: fixed priority, A always beats B on simultaneous requests, and the last pointer is not implemented.
- When undefined: round-robin as described in Behaviour.

Test Plan:
- Logical shift, A only: req_a, data_a=8'hB4, cnt_a=3, asr_a=0.
  - Required: gnt_a in cycle 1, three sh_shift cycles, rsp_valid in cycle 6, rsp_id=0, rsp_data=8'h16.
- Arithmetic shift, B only: req_b, data_b=8'hB4, cnt_b=2, asr_b=1.
  - Required: rsp_id=1, rsp_data=8'hED.
- Zero count: cnt_a=0, data_a=8'h5A.
  - Required: no sh_shift pulses, rsp_valid in cycle 3, rsp_data=8'h5A.
- Saturating count: cnt_b=15, data_b=8'h80, asr_b=0.
  - Required: exactly 8 sh_shift cycles, rsp_data=8'h00.
- Contention: req_a and req_b held high together for two commands.
  - Round-robin build: grants A then B.
  - SHIFTCTL_FIXED_PRIO_EN build: grants A then A.
  - Both builds: rsp_id matches the grant order.
- Mid-operation reset: reset_n=0 for one cycle during SHIFT with cnt=5.
  - Required: next cycle state IDLE, busy=0, sh_shift=0, sh_load_n=1, no rsp_valid.
  - A subsequent request then completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// Two-requester sequencer for a WIDTH-bit load/shift register: arbitrates, loads, shifts, returns result.
// Define SHIFTCTL_FIXED_PRIO_EN for fixed A-over-B priority; default build is round-robin.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic [CNT_W-1:0] cnt_a,
    input  logic             asr_a,
    output logic             gnt_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic [CNT_W-1:0] cnt_b,
    input  logic             asr_b,
    output logic             gnt_b,
    output logic             sh_load_n,
    output logic [WIDTH-1:0] sh_load_val,
    output logic             sh_shift,
    output logic             sh_asr,
    input  logic [WIDTH-1:0] sh_q,
    output logic             busy,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
);
    localparam int REM_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_q;
    logic [REM_W-1:0] rem;
    logic             asr_q;
    logic             id_q;
    logic             accept;
    logic             pick_b;
    logic [CNT_W-1:0] pick_cnt;
    logic [REM_W-1:0] rem_init;

`ifdef SHIFTCTL_FIXED_PRIO_EN
    assign pick_b = !req_a;
`else
    logic last_b;
    // On a tie, the requester that did not win last time goes first.
    assign pick_b = req_b && (!req_a || !last_b);
`endif

    assign accept   = (state == IDLE) && (req_a || req_b);
    assign pick_cnt = pick_b ? cnt_b : cnt_a;
    assign busy     = (state != IDLE);

    always_comb begin
        if (32'(pick_cnt) > 32'(WIDTH)) rem_init = REM_W'(WIDTH);
        else                            rem_init = REM_W'(pick_cnt);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt   = state;
        gnt_a       = 1'b0;
        gnt_b       = 1'b0;
        sh_load_n   = 1'b1;
        sh_load_val = '0;
        sh_shift    = 1'b0;
        sh_asr      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                gnt_a       = !id_q;
                gnt_b       = id_q;
                sh_load_n   = 1'b0;
                sh_load_val = data_q;
                sh_asr      = asr_q;
                state_nxt   = (rem == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                sh_shift = 1'b1;
                sh_asr   = asr_q;
                if (rem == REM_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: command latches are plain flops, so they are reset too; a reset mid-operation discards the command.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q    <= '0;
            rem       <= '0;
            asr_q     <= 1'b0;
            id_q      <= 1'b0;
`ifndef SHIFTCTL_FIXED_PRIO_EN
            last_b    <= 1'b1;
`endif
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            rsp_valid <= 1'b0;
            if (accept) begin
                data_q <= pick_b ? data_b : data_a;
                asr_q  <= pick_b ? asr_b : asr_a;
                rem    <= rem_init;
                id_q   <= pick_b;
`ifndef SHIFTCTL_FIXED_PRIO_EN
                last_b <= pick_b;
`endif
            end
            if (state == SHIFT) rem <= rem - REM_W'(1);
            if (state == DONE) begin
                rsp_data  <= sh_q;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: behavioural shifter, response scoreboard, per-scenario tasks.
module tb_shift_sequencer;
    localparam int WIDTH  = 8;
    localparam int CNT_W  = 4;
    localparam int BUDGET = 40;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_a = 1'b0, req_b = 1'b0;
    logic [WIDTH-1:0] data_a = '0, data_b = '0;
    logic [CNT_W-1:0] cnt_a = '0, cnt_b = '0;
    logic             asr_a = 1'b0, asr_b = 1'b0;
    logic             gnt_a, gnt_b;
    logic             sh_load_n, sh_shift, sh_asr;
    logic [WIDTH-1:0] sh_load_val;
    logic [WIDTH-1:0] sh_q = '0;
    logic             busy, rsp_valid, rsp_id;
    logic [WIDTH-1:0] rsp_data;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   rsp_count = 0;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .data_a(data_a), .cnt_a(cnt_a), .asr_a(asr_a), .gnt_a(gnt_a),
        .req_b(req_b), .data_b(data_b), .cnt_b(cnt_b), .asr_b(asr_b), .gnt_b(gnt_b),
        .sh_load_n(sh_load_n), .sh_load_val(sh_load_val), .sh_shift(sh_shift), .sh_asr(sh_asr),
        .sh_q(sh_q), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    // Shifter register being sequenced.
    always @(posedge clk) begin
        if (!sh_load_n)   sh_q <= sh_load_val;
        else if (sh_shift) sh_q <= {sh_asr & sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    end

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid) begin
            rsp_count++;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL rsp_unexpected: got id=%0d data=%h, expected no response", rsp_id, rsp_data);
            end else begin
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_data !== e.data)
                    $display("FAIL rsp_match: got id=%0d data=%h, expected id=%0d data=%h",
                             rsp_id, rsp_data, e.id, e.data);
                else
                    passed++;
            end
        end
    end

    task automatic issue(input logic b, input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c,
                         input logic s, input logic [WIDTH-1:0] exp_data);
        exp_t e;
        if (b) begin req_b = 1'b1; data_b = d; cnt_b = c; asr_b = s; end
        else   begin req_a = 1'b1; data_a = d; cnt_a = c; asr_a = s; end
        e.id   = b;
        e.data = exp_data;
        sb.push_back(e);
    endtask

    // Runs one command to completion; scrambles the operand inputs once granted.
    task automatic wait_rsp(output bit found, output int gnt_cyc, output logic gnt_id,
                            output int rsp_cyc, output int shifts);
        found = 1'b0; gnt_cyc = 0; gnt_id = 1'b0; rsp_cyc = 0; shifts = 0;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge clk);
            if (sh_shift) shifts++;
            if ((gnt_a || gnt_b) && gnt_cyc == 0) begin
                gnt_cyc = cyc;
                gnt_id  = gnt_b;
            end
            if (gnt_a) begin req_a = 1'b0; data_a = WIDTH'($urandom); cnt_a = CNT_W'($urandom); asr_a = ~asr_a; end
            if (gnt_b) begin req_b = 1'b0; data_b = WIDTH'($urandom); cnt_b = CNT_W'($urandom); asr_b = ~asr_b; end
            if (rsp_valid) begin
                found   = 1'b1;
                rsp_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, rsp_valid, rsp_id, busy, sh_shift, sh_asr} !== 7'b0)
            $display("FAIL reset_ctrl: got %b, expected 0000000", {gnt_a, gnt_b, rsp_valid, rsp_id, busy, sh_shift, sh_asr});
        else passed++;
        checks++;
        if (sh_load_n !== 1'b1) $display("FAIL reset_load_n: got %b, expected 1", sh_load_n);
        else passed++;
        checks++;
        if (rsp_data !== '0 || sh_load_val !== '0)
            $display("FAIL reset_data: got rsp_data=%h load_val=%h, expected 00 00", rsp_data, sh_load_val);
        else passed++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL idle_no_req: got busy=%b rsp=%b, expected 0 0", busy, rsp_valid);
        else passed++;
    endtask

    task automatic test_logical_a();
        bit f; int g, r, s; logic gid;
        issue(1'b0, 8'hB4, 4'd3, 1'b0, 8'h16);
        wait_rsp(f, g, gid, r, s);
        checks++;
        if (!f || g != 1 || gid !== 1'b0) $display("FAIL logical_gnt: got found=%0d gnt_cyc=%0d id=%0d, expected 1 1 0", f, g, gid);
        else passed++;
        checks++;
        if (s != 3 || r != 6) $display("FAIL logical_timing: got shifts=%0d rsp_cyc=%0d, expected 3 6", s, r);
        else passed++;
    endtask

    task automatic test_arith_b();
        bit f; int g, r, s; logic gid;
        issue(1'b1, 8'hB4, 4'd2, 1'b1, 8'hED);
        wait_rsp(f, g, gid, r, s);
        checks++;
        if (!f || g != 1 || gid !== 1'b1) $display("FAIL arith_gnt: got found=%0d gnt_cyc=%0d id=%0d, expected 1 1 1", f, g, gid);
        else passed++;
        checks++;
        if (s != 2 || r != 5) $display("FAIL arith_timing: got shifts=%0d rsp_cyc=%0d, expected 2 5", s, r);
        else passed++;
    endtask

    task automatic test_zero_count();
        bit f; int g, r, s; logic gid;
        issue(1'b0, 8'h5A, 4'd0, 1'b0, 8'h5A);
        wait_rsp(f, g, gid, r, s);
        checks++;
        if (!f || s != 0 || r != 3) $display("FAIL zero_count: got found=%0d shifts=%0d rsp_cyc=%0d, expected 1 0 3", f, s, r);
        else passed++;
    endtask

    task automatic test_saturate();
        bit f; int g, r, s; logic gid;
        issue(1'b1, 8'h80, 4'd15, 1'b0, 8'h00);
        wait_rsp(f, g, gid, r, s);
        checks++;
        if (!f || s != 8 || r != 11) $display("FAIL saturate: got found=%0d shifts=%0d rsp_cyc=%0d, expected 1 8 11", f, s, r);
        else passed++;
    endtask

    // Both requesters held high; A presents a second command after its first grant.
    task automatic test_back_to_back();
        logic [2:0] order, exp_order;
        int         gnt_cyc[3], rsp_cyc[3];
        int         ng = 0, nr = 0, a_cmds = 0;
        order = '0;
        issue(1'b0, 8'hF0, 4'd1, 1'b0, 8'h78);
`ifdef SHIFTCTL_FIXED_PRIO_EN
        exp_order = 3'b100;
        begin exp_t e; e.id = 1'b0; e.data = 8'hE0; sb.push_back(e); end
        issue(1'b1, 8'h3C, 4'd0, 1'b0, 8'h3C);
`else
        exp_order = 3'b010;
        issue(1'b1, 8'h3C, 4'd0, 1'b0, 8'h3C);
        begin exp_t e; e.id = 1'b0; e.data = 8'hE0; sb.push_back(e); end
`endif
        for (int cyc = 1; cyc <= 3 * BUDGET && nr < 3; cyc++) begin
            @(negedge clk);
            if ((gnt_a || gnt_b) && ng < 3) begin
                order[ng]   = gnt_b;
                gnt_cyc[ng] = cyc;
                ng++;
            end
            if (gnt_a) begin
                if (a_cmds == 0) begin data_a = 8'h81; cnt_a = 4'd2; asr_a = 1'b1; end
                else req_a = 1'b0;
                a_cmds++;
            end
            if (gnt_b) req_b = 1'b0;
            if (rsp_valid) begin
                rsp_cyc[nr] = cyc;
                nr++;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        checks++;
        if (ng != 3 || nr != 3) $display("FAIL b2b_count: got grants=%0d rsps=%0d, expected 3 3", ng, nr);
        else passed++;
        checks++;
        if (order !== exp_order) $display("FAIL b2b_order: got %b, expected %b (bit i = id of grant i)", order, exp_order);
        else passed++;
        checks++;
        if (ng == 3 && nr == 3 && (gnt_cyc[1] != rsp_cyc[0] + 1 || gnt_cyc[2] != rsp_cyc[1] + 1))
            $display("FAIL b2b_accept_on_rsp: got gnt=%0d,%0d rsp=%0d,%0d, expected gnt one cycle after rsp",
                     gnt_cyc[1], gnt_cyc[2], rsp_cyc[0], rsp_cyc[1]);
        else if (ng == 3 && nr == 3) passed++;
        else $display("FAIL b2b_accept_on_rsp: got incomplete run, expected three grants and responses");
    endtask

    task automatic test_mid_reset();
        bit f; int g, r, s, base; logic gid;
        bit granted = 1'b0;
        req_a = 1'b1; data_a = 8'hFF; cnt_a = 4'd5; asr_a = 1'b1;
        for (int cyc = 0; cyc < BUDGET && !granted; cyc++) begin
            @(negedge clk);
            if (gnt_a) begin granted = 1'b1; req_a = 1'b0; end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!granted || sh_shift !== 1'b1) $display("FAIL midrst_in_shift: got granted=%0d sh_shift=%b, expected 1 1", granted, sh_shift);
        else passed++;
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sh_shift !== 1'b0 || sh_load_n !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL midrst_idle: got busy=%b shift=%b load_n=%b rsp=%b, expected 0 0 1 0", busy, sh_shift, sh_load_n, rsp_valid);
        else passed++;
        reset_n = 1'b1;
        base = rsp_count;
        repeat (10) @(negedge clk);
        checks++;
        if (rsp_count != base || busy !== 1'b0) $display("FAIL midrst_no_rsp: got rsps=%0d busy=%b, expected 0 0", rsp_count - base, busy);
        else passed++;
        issue(1'b0, 8'hC3, 4'd1, 1'b1, 8'hE1);
        wait_rsp(f, g, gid, r, s);
        checks++;
        if (!f || g != 1 || s != 1 || r != 4)
            $display("FAIL midrst_recover: got found=%0d gnt=%0d shifts=%0d rsp_cyc=%0d, expected 1 1 1 4", f, g, s, r);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_logical_a();
        test_arith_b();
        test_zero_count();
        test_saturate();
        test_back_to_back();
        test_mid_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) $display("FAIL sb_drained: got %0d outstanding, expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
